clk_div_mon: RTL and testbench

- Measurement-side counterpart to the clock generator block (even/odd dividers, 2x multiplier).
- Samples a monitored clock as data in the i_clk domain. Measures its high time, low time and period in i_clk cycles.
- Checks the period against an expected value and reports the result with a valid strobe.
- Used in benches and as an on-chip self-check of the divided clocks. The monitored frequency must be at most i_clk/2, so the 2x clock is not in scope.

---
 rtl/clk_div_mon_pkg.sv | 20 ++
 rtl/sync_edge.sv | 61 ++++++
 rtl/clk_div_mon.sv | 224 ++++++++++++++++++++++
 tb/tb_clk_div_mon.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_mon_pkg
// Shared definitions for the clock-divider monitor:
//   state_e          measurement FSM states
//   CNT_W_DEF        default width of the high/low/period counters
//   SYNC_STAGES_MIN  smallest legal synchronizer depth on the monitored clock
// -----------------------------------------------------------------------------
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the i_clk domain through STAGES flops and
// adds one further flop so the synchronized level can be edge-detected.
// Reusable for any slow asynchronous level input.
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous, active-high reset
//   i_d      asynchronous level input
//   o_level  synchronized level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
//   o_fall   one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge
  import clk_div_mon_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_depth
    $error("sync_edge: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d[0] = i_d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours and the shift
  // chain cannot collapse into a single stage in simulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/clk_div_mon.sv
// -----------------------------------------------------------------------------
// clk_div_mon
// Measures the high time, low time and period of a slow monitored clock
// (at most i_clk/2), sampled as data in the i_clk domain, and checks the
// period against an expected value with an absolute tolerance.
//
// Optional feature macro: CLK_DIV_MON_DUTY_CHK_EN
//   defined   -> sticky o_duty_err when |high - low| > 1 at a result update
//   undefined -> o_duty_err tied to 0, no comparator built
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous, active-high reset
//   i_en          measurement enable (level); low returns the FSM to IDLE
//   i_clr         one-cycle pulse clearing the sticky flags
//   i_clk_mon     monitored clock, treated as an asynchronous data input
//   i_exp_period  expected period in i_clk cycles
//   i_tol         allowed absolute period deviation
//   o_high_cnt    last measured high time
//   o_low_cnt     last measured low time
//   o_period      last measured period (high + low, saturating)
//   o_valid       one-cycle pulse when new results are latched
//   o_err         sticky: period outside tolerance
//   o_timeout     sticky: a phase counter saturated (stuck clock)
//   o_duty_err    sticky: duty-cycle error (optional feature)
// -----------------------------------------------------------------------------
module clk_div_mon
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_clk_mon,
  input  logic [CNT_W-1:0] i_exp_period,
  input  logic [CNT_W-1:0] i_tol,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_low_cnt,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_timeout,
  output logic             o_duty_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The edges carry everything the FSM needs; the level is left unused.
  logic unused_level;
  logic mon_rise;
  logic mon_fall;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_d     (i_clk_mon),
    .o_level (unused_level),
    .o_rise  (mon_rise),
    .o_fall  (mon_fall)
  );

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] high_q,     high_d;      // high time of the phase pair in progress
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q,  low_cnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  logic             valid_q,    valid_d;
  logic             err_q,      err_d;
  logic             timeout_q,  timeout_d;

  // Period and tolerance arithmetic on the pair that completes this cycle.
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] period_sat;
  logic [CNT_W:0]   per_ext;
  logic [CNT_W:0]   exp_ext;
  logic [CNT_W:0]   abs_dev;
  logic             period_bad;
  logic             cnt_max;

  always_comb begin
    sum        = {1'b0, high_q} + {1'b0, cnt_q};
    period_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    per_ext    = {1'b0, period_sat};
    exp_ext    = {1'b0, i_exp_period};
    abs_dev    = (per_ext >= exp_ext) ? (per_ext - exp_ext) : (exp_ext - per_ext);
    period_bad = abs_dev > {1'b0, i_tol};
    cnt_max    = &cnt_q;
  end

  logic new_err;
  logic new_timeout;

  // NOTE: every signal written here gets a default before the case
  // statement, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_d      = high_q;
    high_cnt_d  = high_cnt_q;
    low_cnt_d   = low_cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    new_err     = 1'b0;
    new_timeout = 1'b0;

    if (!i_en) begin
      // In-progress counts are dropped; the latched results are kept.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;

        ARM: begin
          // Phase already in progress at arm time is never measured.
          if (mon_rise) begin
            cnt_d   = CNT_ONE;
            state_d = HIGH;
          end
        end

        HIGH: begin
          // Saturation outranks a coincident edge: the phase is unmeasurable.
          if (cnt_max) begin
            new_timeout = 1'b1;
            state_d     = ARM;
          end else if (mon_fall) begin
            high_d  = cnt_q;
            cnt_d   = CNT_ONE;
            state_d = LOW;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        LOW: begin
          if (cnt_max) begin
            new_timeout = 1'b1;
            state_d     = ARM;
          end else if (mon_rise) begin
            high_cnt_d = high_q;
            low_cnt_d  = cnt_q;
            period_d   = period_sat;
            valid_d    = 1'b1;
            new_err    = period_bad;
            cnt_d      = CNT_ONE;
            state_d    = HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // A new error in the same cycle as i_clr wins.
    err_d     = (err_q & ~i_clr) | new_err;
    timeout_d = (timeout_q & ~i_clr) | new_timeout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef CLK_DIV_MON_DUTY_CHK_EN
  // Tolerating a difference of 1 accepts both exact 50% (even division)
  // and the N/2 rounding of odd division.
  logic [CNT_W-1:0] hl_dev;
  logic             duty_bad;
  logic             duty_q, duty_d;

  always_comb begin
    hl_dev   = (high_q >= cnt_q) ? (high_q - cnt_q) : (cnt_q - high_q);
    duty_bad = hl_dev > CNT_ONE;
    duty_d   = (duty_q & ~i_clr) | (valid_d & duty_bad);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      duty_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign o_duty_err = duty_q;
`else
  assign o_duty_err = 1'b0;
`endif

  assign o_high_cnt = high_cnt_q;
  assign o_low_cnt  = low_cnt_q;
  assign o_period   = period_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// -----------------------------------------------------------------------------
// tb_clk_div_mon
// Drives the monitored clock as a sequence of (high, low) phase pairs counted
// in i_clk cycles. Each completed pair that the monitor can measure pushes its
// expected result into a queue; a separate monitor process pops and compares
// whenever o_valid is seen.
// -----------------------------------------------------------------------------
module tb_clk_div_mon;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

`ifdef CLK_DIV_MON_DUTY_CHK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             clr;
  logic             mon;
  logic [CNT_W-1:0] exp_p;
  logic [CNT_W-1:0] tol;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             err;
  logic             timeout;
  logic             duty_err;

  clk_div_mon #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_clr        (clr),
    .i_clk_mon    (mon),
    .i_exp_period (exp_p),
    .i_tol        (tol),
    .o_high_cnt   (high_cnt),
    .o_low_cnt    (low_cnt),
    .o_period     (period),
    .o_valid      (valid),
    .o_err        (err),
    .o_timeout    (timeout),
    .o_duty_err   (duty_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int p;
    bit e;
    bit t;
    bit d;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Sticky-flag reference state.
  bit m_err  = 1'b0;
  bit m_to   = 1'b0;
  bit m_duty = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_err  = 1'b0;
    m_to   = 1'b0;
    m_duty = 1'b0;
  endtask

  // Reference rule for one complete high/low pair followed by a rise.
  task automatic score_pair(input int h, input int l);
    exp_t e;
    int   dev;
    if (h >= CMAX || l >= CMAX) begin
      m_to = 1'b1;
    end else begin
      e.h = h;
      e.l = l;
      e.p = (h + l > CMAX) ? CMAX : h + l;
      dev = e.p - int'(exp_p);
      if (dev < 0) dev = -dev;
      if (dev > int'(tol)) m_err = 1'b1;
      if (DUTY_ON && (h - l > 1 || l - h > 1)) m_duty = 1'b1;
      e.e = m_err;
      e.t = m_to;
      e.d = m_duty;
      q.push_back(e);
    end
  endtask

  // One monitored-clock pair. With do_clr (needs h >= 5) i_clr is pulsed
  // mid-high, after the previous pair's result has been presented.
  task automatic pair(input int h, input int l, input bit do_clr = 1'b0);
    mon = 1'b1;
    if (do_clr) begin
      cyc(3);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      clear_model();
      cyc(1);
      check("clr_err", err, 0);
      check("clr_timeout", timeout, 0);
      check("clr_duty", duty_err, 0);
      cyc(h - 5);
    end else begin
      cyc(h);
    end
    mon = 1'b0;
    cyc(l);
    score_pair(h, l);
  endtask

  // Drop i_en during a low phase, clear flags and load a new configuration;
  // the interrupted pair produces no result.
  task automatic restart(input int e, input int t);
    mon = 1'b1;
    cyc(4);
    mon   = 1'b0;
    en    = 1'b0;
    clr   = 1'b1;
    exp_p = CNT_W'(e);
    tol   = CNT_W'(t);
    cyc(1);
    clr = 1'b0;
    cyc(1);
    en = 1'b1;
    clear_model();
    cyc(8);
  endtask

  // Monitor: compares every presented result against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got high=%0d low=%0d period=%0d expected no result at %0t",
                   high_cnt, low_cnt, period, $time);
        end else begin
          e = q.pop_front();
          check("high_cnt", high_cnt, e.h);
          check("low_cnt", low_cnt, e.l);
          check("period", period, e.p);
          check("err", err, e.e);
          check("timeout", timeout, e.t);
          check("duty_err", duty_err, e.d);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2 ms");
    $fatal(1);
  end

  initial begin
    int h;
    int l;
    rst   = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    mon   = 1'b0;
    exp_p = CNT_W'(4);
    tol   = '0;
    cyc(3);
    check("rst_valid", valid, 0);
    check("rst_period", period, 0);
    check("rst_err", err, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(8);

    // i_clk/4, exact expectation.
    repeat (6) pair(2, 2);

    // i_clk/5, odd division rounding both ways.
    restart(5, 0);
    repeat (3) begin
      pair(3, 2);
      pair(2, 3);
    end

    // i_clk/6 against expected 4 +/- 1: sticky error, clear and reassert.
    restart(4, 1);
    repeat (3) pair(3, 3);
    pair(5, 1, 1'b1);
    repeat (2) pair(3, 3);

    // Randomized pairs and configurations.
    repeat (3) begin
      restart($urandom_range(3, 10), $urandom_range(0, 2));
      repeat (15) begin
        h = $urandom_range(1, 8);
        l = $urandom_range(1, 8);
        pair(h, l, (h >= 5) && ($urandom_range(0, 3) == 0));
      end
    end

    // Saturating period sum, then stuck high and stuck low.
    restart(CMAX, 0);
    pair(200, 100);
    pair(2, CMAX - 1);
    pair(CMAX, 3);
    pair(2, 2);
    pair(3, 300);
    check("stuck_low_timeout", timeout, 1);
    pair(2, 2);
    pair(2, 2);

    // Reset in the middle of a high phase.
    restart(4, 0);
    repeat (2) pair(2, 2);
    mon = 1'b1;
    cyc(5);
    rst = 1'b1;
    mon = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_high", high_cnt, 0);
    check("midrst_low", low_cnt, 0);
    check("midrst_period", period, 0);
    check("midrst_err", err, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_duty", duty_err, 0);
    check("midrst_pending", q.size(), 0);
    clear_model();
    cyc(3);
    rst = 1'b0;
    cyc(6);
    pair(3, 2);
    pair(2, 2);
    pair(4, 4);

    // Close the last pair and let its result drain.
    mon = 1'b1;
    cyc(10);
    mon = 1'b0;
    cyc(5);
    check("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
